// File: rtl/conv_pkg.sv
// Shared definitions for the convolution operand path.
//   fsm_e       : streamer sequencing states.
//   total_taps  : number of (a, b) pairs one full pass produces.
package conv_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN
   } fsm_e;

   // Pass length, shared with the controller so both sides agree on pair count.
   function automatic logic [63:0] total_taps(input int unsigned w, input int unsigned h,
                                              input int unsigned cin, input int unsigned cout,
                                              input int unsigned k);
      return 64'(w) * 64'(h) * 64'(cin) * 64'(cout) * 64'(k) * 64'(k);
   endfunction

endpackage

// File: rtl/operand_skid_fifo.sv
// Two-entry FIFO holding {a, b} operand pairs between memory return and the consumer.
// Ports:
//   clk, arst_in        : clock, asynchronous active-high reset
//   push, push_data     : write one entry (caller guarantees a free slot)
//   pop                 : retire the head entry (caller guarantees non-empty)
//   pop_data            : head entry, stable until popped
//   occupancy, empty    : fill level 0..2, and occupancy == 0
module operand_skid_fifo #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             arst_in,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic [1:0]       occupancy,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       count_q;

   always_ff @(posedge clk or posedge arst_in) begin
      if (arst_in) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_q + 2'(push) - 2'(pop);
      end
   end

   assign pop_data  = mem_q[rd_ptr_q];
   assign occupancy = count_q;
   assign empty     = (count_q == 2'd0);

endmodule

// File: rtl/operand_streamer.sv
// Transmit side of the a/b operand interface: walks x, y, ch_in, ch_out, k_v, k_h
// (k_h innermost), reads activation/weight memories and streams (a, b) pairs.
// Out-of-bounds taps are zero-padded without an activation read.
// Ports:
//   clk, arst_in                   : clock, asynchronous active-high reset
//   start, busy, done              : pass control / status (done is a 1-cycle pulse)
//   act_re, act_addr, act_rdata    : activation memory, 1-cycle read latency
//   wgt_re, wgt_addr, wgt_rdata    : weight memory, 1-cycle read latency
//   a_valid/a_ready/a_data         : activation operand (lockstep with b)
//   b_valid/b_ready/b_data         : weight operand
//   stall_cycles                   : only with OPERAND_STREAMER_STALL_CNT_EN defined;
//                                    saturating count of valid-but-not-accepted cycles
module operand_streamer
   import conv_pkg::*;
#(
   parameter int unsigned LOG2_OF_MEM_HEIGHT = 20,
   parameter int unsigned FEATURE_MAP_WIDTH  = 1024,
   parameter int unsigned FEATURE_MAP_HEIGHT = 1024,
   parameter int unsigned INPUT_NB_CHANNELS  = 64,
   parameter int unsigned OUTPUT_NB_CHANNELS = 64,
   parameter int unsigned KERNEL_SIZE        = 3,
   parameter int unsigned DATA_WIDTH         = 16
) (
   input  logic                          clk,
   input  logic                          arst_in,
   input  logic                          start,
   output logic                          busy,
   output logic                          done,
   output logic                          act_re,
   output logic [LOG2_OF_MEM_HEIGHT-1:0] act_addr,
   input  logic [DATA_WIDTH-1:0]         act_rdata,
   output logic                          wgt_re,
   output logic [LOG2_OF_MEM_HEIGHT-1:0] wgt_addr,
   input  logic [DATA_WIDTH-1:0]         wgt_rdata,
`ifdef OPERAND_STREAMER_STALL_CNT_EN
   output logic [31:0]                   stall_cycles,
`endif
   output logic                          a_valid,
   input  logic                          a_ready,
   output logic [DATA_WIDTH-1:0]         a_data,
   output logic                          b_valid,
   input  logic                          b_ready,
   output logic [DATA_WIDTH-1:0]         b_data
);

   localparam int unsigned XW  = (FEATURE_MAP_WIDTH > 1) ? $clog2(FEATURE_MAP_WIDTH) : 1;
   localparam int unsigned YW  = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1;
   localparam int unsigned CIW = (INPUT_NB_CHANNELS > 1) ? $clog2(INPUT_NB_CHANNELS) : 1;
   localparam int unsigned COW = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1;
   localparam int unsigned KW  = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;

   fsm_e state_q, state_d;

   logic [XW-1:0]  x_q, x_d;
   logic [YW-1:0]  y_q, y_d;
   logic [CIW-1:0] ch_in_q, ch_in_d;
   logic [COW-1:0] ch_out_q, ch_out_d;
   logic [KW-1:0]  k_v_q, k_v_d;
   logic [KW-1:0]  k_h_q, k_h_d;

   logic inflight_q;
   logic pad_q;

   logic                    issue, pop, pad, last_tap, drained;
   logic                    fifo_empty;
   logic [1:0]              occupancy;
   logic [2:0]              slots_used;
   logic [2*DATA_WIDTH-1:0] push_data, pop_data;
   logic signed [32:0]      xi, yi;
   logic                    kh_last, kv_last, co_last, ci_last, y_last, x_last;
   logic                    c_kv, c_co, c_ci, c_y, c_x;

   // ---------------- tap counters ----------------
   assign kh_last = (k_h_q == KW'(KERNEL_SIZE - 1));
   assign kv_last = (k_v_q == KW'(KERNEL_SIZE - 1));
   assign co_last = (ch_out_q == COW'(OUTPUT_NB_CHANNELS - 1));
   assign ci_last = (ch_in_q == CIW'(INPUT_NB_CHANNELS - 1));
   assign y_last  = (y_q == YW'(FEATURE_MAP_HEIGHT - 1));
   assign x_last  = (x_q == XW'(FEATURE_MAP_WIDTH - 1));

   // Carry chain: a counter steps when every inner counter wraps on this issue.
   assign c_kv     = issue & kh_last;
   assign c_co     = c_kv & kv_last;
   assign c_ci     = c_co & co_last;
   assign c_y      = c_ci & ci_last;
   assign c_x      = c_y & y_last;
   assign last_tap = c_x & x_last;

   always_comb begin
      k_h_d    = k_h_q;
      k_v_d    = k_v_q;
      ch_out_d = ch_out_q;
      ch_in_d  = ch_in_q;
      y_d      = y_q;
      x_d      = x_q;
      if (issue) k_h_d = kh_last ? '0 : k_h_q + KW'(1);
      if (c_kv)  k_v_d = kv_last ? '0 : k_v_q + KW'(1);
      if (c_co)  ch_out_d = co_last ? '0 : ch_out_q + COW'(1);
      if (c_ci)  ch_in_d = ci_last ? '0 : ch_in_q + CIW'(1);
      if (c_y)   y_d = y_last ? '0 : y_q + YW'(1);
      if (c_x)   x_d = x_last ? '0 : x_q + XW'(1);
   end

   always_ff @(posedge clk or posedge arst_in) begin
      if (arst_in) begin
         x_q        <= '0;
         y_q        <= '0;
         ch_in_q    <= '0;
         ch_out_q   <= '0;
         k_v_q      <= '0;
         k_h_q      <= '0;
         inflight_q <= 1'b0;
         pad_q      <= 1'b0;
      end else begin
         x_q        <= x_d;
         y_q        <= y_d;
         ch_in_q    <= ch_in_d;
         ch_out_q   <= ch_out_d;
         k_v_q      <= k_v_d;
         k_h_q      <= k_h_d;
         inflight_q <= issue;
         pad_q      <= pad;
      end
   end

   // ---------------- address generation ----------------
   assign xi  = $signed(33'(x_q) + 33'(k_h_q) - 33'(KERNEL_SIZE / 2));
   assign yi  = $signed(33'(y_q) + 33'(k_v_q) - 33'(KERNEL_SIZE / 2));
   assign pad = xi[32] || (xi >= $signed(33'(FEATURE_MAP_WIDTH)))
             || yi[32] || (yi >= $signed(33'(FEATURE_MAP_HEIGHT)));

   // Only slots_used < 2 is issued, so every read in flight already owns a FIFO slot.
   assign pop        = a_valid & a_ready & b_ready;
   assign slots_used = {1'b0, occupancy} + 3'(inflight_q) - 3'(pop);
   assign issue      = (state_q == ISSUE) && (slots_used < 3'd2);

   assign act_re = issue & ~pad;
   assign wgt_re = issue;

   // Zero when idle so the address buses stay quiet outside real reads.
   assign act_addr = act_re
      ? LOG2_OF_MEM_HEIGHT'((64'(yi) * 64'(FEATURE_MAP_WIDTH) + 64'(xi))
                            * 64'(INPUT_NB_CHANNELS) + 64'(ch_in_q))
      : '0;
   assign wgt_addr = wgt_re
      ? LOG2_OF_MEM_HEIGHT'(((64'(ch_out_q) * 64'(INPUT_NB_CHANNELS) + 64'(ch_in_q))
                             * 64'(KERNEL_SIZE) + 64'(k_v_q)) * 64'(KERNEL_SIZE) + 64'(k_h_q))
      : '0;

   // ---------------- return buffer ----------------
   assign push_data = {(pad_q ? '0 : act_rdata), wgt_rdata};

   operand_skid_fifo #(
      .WIDTH(2 * DATA_WIDTH)
   ) u_fifo (
      .clk      (clk),
      .arst_in  (arst_in),
      .push     (inflight_q),
      .push_data(push_data),
      .pop      (pop),
      .pop_data (pop_data),
      .occupancy(occupancy),
      .empty    (fifo_empty)
   );

   assign a_valid = ~fifo_empty;
   assign b_valid = ~fifo_empty;
   assign a_data  = pop_data[2*DATA_WIDTH-1:DATA_WIDTH];
   assign b_data  = pop_data[DATA_WIDTH-1:0];

   // ---------------- sequencing FSM ----------------
   assign drained = fifo_empty & ~inflight_q;

   always_ff @(posedge clk or posedge arst_in) begin
      if (arst_in) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = ISSUE;
         ISSUE:   if (last_tap) state_d = DRAIN;
         DRAIN:   if (drained) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q != IDLE);
      done = (state_q == DRAIN) && drained;
   end

`ifdef OPERAND_STREAMER_STALL_CNT_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk or posedge arst_in) begin
      if (arst_in) begin
         stall_q <= '0;
      end else if (state_q == IDLE) begin
         if (start) stall_q <= '0;
      end else if (a_valid && !(a_ready && b_ready) && (stall_q != '1)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_operand_streamer.sv
module tb_operand_streamer;

   localparam int unsigned AW = 8, DW = 16;
   localparam int W = 4, H = 4, CIN = 2, COUT = 2, K = 3;
   localparam int NPAIRS = 576;

   logic          clk = 1'b0;
   logic          arst_in, start, busy, done;
   logic          act_re, wgt_re;
   logic [AW-1:0] act_addr, wgt_addr;
   logic [DW-1:0] act_rdata, wgt_rdata;
   logic          a_valid, a_ready, b_valid, b_ready;
   logic [DW-1:0] a_data, b_data;
`ifdef OPERAND_STREAMER_STALL_CNT_EN
   logic [31:0]   stall_cycles;
`endif

   always #5 clk = ~clk;

   operand_streamer #(
      .LOG2_OF_MEM_HEIGHT(AW),
      .FEATURE_MAP_WIDTH (W),
      .FEATURE_MAP_HEIGHT(H),
      .INPUT_NB_CHANNELS (CIN),
      .OUTPUT_NB_CHANNELS(COUT),
      .KERNEL_SIZE       (K),
      .DATA_WIDTH        (DW)
   ) dut (
      .clk         (clk),
      .arst_in     (arst_in),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .act_re      (act_re),
      .act_addr    (act_addr),
      .act_rdata   (act_rdata),
      .wgt_re      (wgt_re),
      .wgt_addr    (wgt_addr),
      .wgt_rdata   (wgt_rdata),
`ifdef OPERAND_STREAMER_STALL_CNT_EN
      .stall_cycles(stall_cycles),
`endif
      .a_valid     (a_valid),
      .a_ready     (a_ready),
      .a_data      (a_data),
      .b_valid     (b_valid),
      .b_ready     (b_ready),
      .b_data      (b_data)
   );

   // Single-port read memories with one-cycle latency.
   logic [DW-1:0] mem_a [256];
   logic [DW-1:0] mem_w [256];

   always @(posedge clk) begin
      if (act_re) act_rdata <= mem_a[act_addr];
      if (wgt_re) wgt_rdata <= mem_w[wgt_addr];
   end

   typedef struct packed {
      logic [DW-1:0] a;
      logic [DW-1:0] b;
   } pair_t;

   typedef struct {
      int            idx;
      logic          re;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
   } vec_t;

   pair_t q[$];
   vec_t  vecs[6];

   int checks = 0, failures = 0;
   int cyc = 0, pop_cnt = 0, done_cnt = 0, issue_idx = 0;
   int last_pop_cyc = 0, done_cyc = 0, base_pops = 0, base_done = 0;
   int start_cyc = 0, first_re = -1, first_valid = -1;
   int stall_left = 0;
   bit rand_rdy = 0, cap_en = 0, prev_stall = 0;
   logic [DW-1:0] prev_a, prev_b;
   logic [DW-1:0] cap_a [NPAIRS];
   logic [DW-1:0] cap_b [NPAIRS];
   logic          cap_re [NPAIRS];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Golden pair sequence for one pass, pushed when the pass is launched.
   task automatic build_expected();
      pair_t p;
      int    xi, yi;
      for (int x = 0; x < W; x++)
         for (int y = 0; y < H; y++)
            for (int ci = 0; ci < CIN; ci++)
               for (int co = 0; co < COUT; co++)
                  for (int kv = 0; kv < K; kv++)
                     for (int kh = 0; kh < K; kh++) begin
                        xi  = x + kh - K / 2;
                        yi  = y + kv - K / 2;
                        p.b = mem_w[8'(((co * CIN + ci) * K + kv) * K + kh)];
                        if (xi < 0 || xi >= W || yi < 0 || yi >= H) p.a = '0;
                        else p.a = mem_a[8'((yi * W + xi) * CIN + ci)];
                        q.push_back(p);
                     end
   endtask

   task automatic sample();
      pair_t exp_p;
      int    idx;
      chk("valid_lockstep", 64'(a_valid), 64'(b_valid));
      if (act_re) chk("act_re_without_wgt_re", 64'(wgt_re), 64'(1));
      if (prev_stall) begin
         chk("hold_valid", 64'(a_valid), 64'(1));
         chk("hold_a", 64'(a_data), 64'(prev_a));
         chk("hold_b", 64'(b_data), 64'(prev_b));
      end
      if (start && !busy) begin
         start_cyc   = cyc;
         first_re    = -1;
         first_valid = -1;
      end else begin
         if (wgt_re && first_re < 0) first_re = cyc;
         if (a_valid && first_valid < 0) first_valid = cyc;
      end
      if (a_valid && a_ready && b_ready) begin
         checks++;
         if (q.size() == 0) begin
            failures++;
            $display("FAIL extra_pair: got pair %0d expected none", pop_cnt - base_pops);
         end else begin
            exp_p = q.pop_front();
            chk("pair_a", 64'(a_data), 64'(exp_p.a));
            chk("pair_b", 64'(b_data), 64'(exp_p.b));
         end
         idx = pop_cnt - base_pops;
         if (cap_en && idx < NPAIRS) begin
            cap_a[10'(idx)] = a_data;
            cap_b[10'(idx)] = b_data;
         end
         pop_cnt++;
         last_pop_cyc = cyc;
      end
      if (wgt_re) begin
         if (cap_en && issue_idx < NPAIRS) cap_re[10'(issue_idx)] = act_re;
         issue_idx++;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      prev_stall = a_valid && !(a_ready && b_ready);
      prev_a     = a_data;
      prev_b     = b_data;
      cyc++;
   endtask

   task automatic tick();
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
      if (stall_left > 0) begin
         a_ready = 1'b0;
         b_ready = 1'b0;
         stall_left--;
      end else if (rand_rdy) begin
         a_ready = 1'($urandom_range(0, 1));
         b_ready = ($urandom_range(0, 3) == 0) ? ~a_ready : a_ready;
      end else begin
         a_ready = 1'b1;
         b_ready = 1'b1;
      end
   endtask

   task automatic start_pass();
      q.delete();
      build_expected();
      base_pops = pop_cnt;
      base_done = done_cnt;
      issue_idx = 0;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   task automatic wait_done(input bit kick50, input int stall_at);
      int n      = 0;
      bit kicked = 0, stalled = 0;
      while (done_cnt == base_done && n < 8000) begin
         if (kick50 && !kicked && (pop_cnt - base_pops) >= 50) begin
            start  = 1'b1;
            kicked = 1;
         end else begin
            start = 1'b0;
         end
         if (stall_at > 0 && !stalled && (pop_cnt - base_pops) >= stall_at) begin
            stall_left = 10;
            stalled    = 1;
         end
         tick();
         n++;
      end
      start = 1'b0;
      checks++;
      if (done_cnt == base_done) begin
         failures++;
         $display("FAIL done_timeout: got no done after %0d cycles, required done", n);
      end
   endtask

   task automatic post_checks();
      chk("pair_count", 64'(pop_cnt - base_pops), 64'(NPAIRS));
      chk("queue_empty", 64'(q.size()), 64'(0));
      chk("done_after_last_pop", 64'(done_cyc - last_pop_cyc), 64'(1));
      tick();
      tick();
      tick();
      chk("done_once", 64'(done_cnt - base_done), 64'(1));
      chk("idle_busy", 64'(busy), 64'(0));
   endtask

   initial begin
      int n;
      for (int i = 0; i < 256; i++) begin
         mem_a[i] = DW'(i * 37 + 1000);
         mem_w[i] = DW'(i * 101 + 32768);
      end
      // {pair index, act_re at its issue, a, b}
      vecs[0] = '{0,   1'b0, 16'h0,    mem_w[0]};   // x=0,y=0: top-left tap padded
      vecs[1] = '{4,   1'b1, mem_a[0], mem_w[4]};   // centre tap of pixel (0,0)
      vecs[2] = '{13,  1'b1, mem_a[0], mem_w[22]};  // ch_out=1, centre tap
      vecs[3] = '{22,  1'b1, mem_a[1], mem_w[13]};  // ch_in=1, ch_out=0, centre tap
      vecs[4] = '{548, 1'b0, 16'h0,    mem_w[8]};   // x=3,y=3,ci=0,co=0,kv=2,kh=2
      vecs[5] = '{575, 1'b0, 16'h0,    mem_w[35]};  // x=3,y=3,ci=1,co=1,kv=2,kh=2

      arst_in = 1'b0;
      start   = 1'b0;
      a_ready = 1'b1;
      b_ready = 1'b1;
      #1 arst_in = 1'b1;
      #1;
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_act_re", 64'(act_re), 64'(0));
      chk("rst_wgt_re", 64'(wgt_re), 64'(0));
      chk("rst_a_valid", 64'(a_valid), 64'(0));
      chk("rst_b_valid", 64'(b_valid), 64'(0));
      chk("rst_act_addr", 64'(act_addr), 64'(0));
      chk("rst_wgt_addr", 64'(wgt_addr), 64'(0));
      chk("rst_a_data", 64'(a_data), 64'(0));
      chk("rst_b_data", 64'(b_data), 64'(0));
      tick();
      tick();
      arst_in = 1'b0;
      tick();

      // Pass 1: full ready, capture for table checks.
      cap_en = 1;
      start_pass();
      wait_done(0, 0);
      cap_en = 0;
      chk("lat_first_read", 64'(first_re - start_cyc), 64'(1));
      chk("lat_first_valid", 64'(first_valid - start_cyc), 64'(3));
      chk("full_rate", 64'(last_pop_cyc - first_valid), 64'(NPAIRS - 1));
      post_checks();
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("vec%0d_act_re", vecs[i].idx), 64'(cap_re[10'(vecs[i].idx)]),
             64'(vecs[i].re));
         chk($sformatf("vec%0d_a", vecs[i].idx), 64'(cap_a[10'(vecs[i].idx)]), 64'(vecs[i].a));
         chk($sformatf("vec%0d_b", vecs[i].idx), 64'(cap_b[10'(vecs[i].idx)]), 64'(vecs[i].b));
      end

      // Pass 2: random ready, stray start at pair 50.
      rand_rdy = 1;
      start_pass();
      wait_done(1, 0);
      rand_rdy = 0;
      post_checks();

      // Pass 3: reset at pair 100.
      start_pass();
      n = 0;
      while ((pop_cnt - base_pops) < 100 && n < 2000) begin
         tick();
         n++;
      end
      chk("abort_reached", 64'(pop_cnt - base_pops), 64'(100));
      arst_in = 1'b1;
      #1;
      chk("abort_busy", 64'(busy), 64'(0));
      chk("abort_a_valid", 64'(a_valid), 64'(0));
      chk("abort_b_valid", 64'(b_valid), 64'(0));
      chk("abort_wgt_re", 64'(wgt_re), 64'(0));
      prev_stall = 0;
      tick();
      arst_in = 1'b0;
      tick();
      tick();
      chk("abort_no_more_pairs", 64'(pop_cnt - base_pops), 64'(100));
      chk("abort_no_done", 64'(done_cnt - base_done), 64'(0));

      // Pass 4: restart from pair 0 after the abort.
      start_pass();
      wait_done(0, 0);
      post_checks();

`ifdef OPERAND_STREAMER_STALL_CNT_EN
      // Pass 5: ten ready-low cycles with a pair waiting.
      start_pass();
      wait_done(0, 20);
      chk("stall_cycles", 64'(stall_cycles), 64'(10));
      post_checks();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
